// File: rtl/ascon_ctrl.sv
// Sequencing controller for the Ascon-128 permutation datapath.
// Walks one authenticated encryption per start: 12-round init, 6-round
// absorption per AD block and per non-final PT block, 12-round finalization,
// then holds the tag until the consumer takes it.
// Optional build macro ASCON_CTRL_ABORT_EN adds an abort_i input that drops
// any message in flight and returns to IDLE on the next cycle.
module ascon_ctrl #(
  parameter  int PA_ROUNDS   = 12,
  parameter  int PB_ROUNDS   = 6,
  parameter  int CNT_WIDTH   = 8,
  localparam int ROUND_WIDTH = $clog2(PA_ROUNDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   ad_blocks_i,
  input  logic [CNT_WIDTH-1:0]   pt_blocks_i,
  input  logic                   ad_valid_i,
  output logic                   ad_ready_o,
  input  logic                   pt_valid_i,
  output logic                   pt_ready_o,
  input  logic                   tag_ready_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   busy_o,
  output logic                   en_state_o,
  output logic                   sel_ad_o,
  output logic                   sel_state_init_o,
  output logic                   sel_xor_init_o,
  output logic                   sel_xor_ext_o,
  output logic                   sel_xor_dom_sep_o,
  output logic                   sel_xor_fin_o,
  output logic                   sel_xor_tag_o,
  output logic                   ct_valid_o,
  output logic                   tag_valid_o,
  output logic [ROUND_WIDTH-1:0] rnd_o
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_WAIT,
    AD_RND,
    PT_WAIT,
    PT_RND,
    FIN,
    DONE
  } state_t;

  localparam logic [ROUND_WIDTH-1:0] RND_ZERO     = '0;
  localparam logic [ROUND_WIDTH-1:0] RND_ONE      = ROUND_WIDTH'(1);
  localparam logic [ROUND_WIDTH-1:0] RND_PB_FIRST = ROUND_WIDTH'(PA_ROUNDS - PB_ROUNDS);
  localparam logic [ROUND_WIDTH-1:0] RND_LAST     = ROUND_WIDTH'(PA_ROUNDS - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO     = '0;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE      = CNT_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [ROUND_WIDTH-1:0] rnd, rnd_nxt;
  logic [CNT_WIDTH-1:0]   ad_left, ad_left_nxt;
  logic [CNT_WIDTH-1:0]   pt_left, pt_left_nxt;
  logic [ROUND_WIDTH-1:0] pt_wait_rnd;
  logic                   pt_last;
  logic                   abort;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // The final PT block skips the 6-round absorb and goes straight into
  // finalization, so its wait cycle presents round 0 instead of round 6.
  assign pt_last     = (pt_left <= CNT_ONE);
  assign pt_wait_rnd = pt_last ? RND_ZERO : RND_PB_FIRST;
  assign rnd_o       = rnd;

  // State, round index and block counters; reset abandons any message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rnd     <= RND_ZERO;
      ad_left <= CNT_ZERO;
      pt_left <= CNT_ZERO;
    end else begin
      state   <= state_nxt;
      rnd     <= rnd_nxt;
      ad_left <= ad_left_nxt;
      pt_left <= pt_left_nxt;
    end
  end

  // Next-state, next-round and strobe decode; only valid-gated strobes
  // in the WAIT states depend combinationally on inputs.
  always_comb begin
    state_nxt         = state;
    rnd_nxt           = rnd;
    ad_left_nxt       = ad_left;
    pt_left_nxt       = pt_left;
    busy_o            = (state != IDLE);
    en_state_o        = 1'b0;
    sel_ad_o          = 1'b0;
    sel_state_init_o  = 1'b0;
    sel_xor_init_o    = 1'b0;
    sel_xor_ext_o     = 1'b0;
    sel_xor_dom_sep_o = 1'b0;
    sel_xor_fin_o     = 1'b0;
    sel_xor_tag_o     = 1'b0;
    ct_valid_o        = 1'b0;
    tag_valid_o       = 1'b0;
    ad_ready_o        = 1'b0;
    pt_ready_o        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt   = INIT;
          rnd_nxt     = RND_ZERO;
          ad_left_nxt = ad_blocks_i;
          pt_left_nxt = (pt_blocks_i == CNT_ZERO) ? CNT_ONE : pt_blocks_i;
        end
      end

      INIT: begin
        en_state_o       = 1'b1;
        sel_state_init_o = (rnd == RND_ZERO);
        if (rnd == RND_LAST) begin
          sel_xor_init_o    = 1'b1;
          sel_xor_dom_sep_o = (ad_left == CNT_ZERO);
          if (ad_left != CNT_ZERO) begin
            state_nxt = AD_WAIT;
            rnd_nxt   = RND_PB_FIRST;
          end else begin
            state_nxt = PT_WAIT;
            rnd_nxt   = pt_wait_rnd;
          end
        end else begin
          rnd_nxt = rnd + RND_ONE;
        end
      end

      AD_WAIT: begin
        ad_ready_o = 1'b1;
        sel_ad_o   = 1'b1;
        if (ad_valid_i) begin
          en_state_o    = 1'b1;
          sel_xor_ext_o = 1'b1;
          if (ad_left != CNT_ZERO) begin
            ad_left_nxt = ad_left - CNT_ONE;
          end
          state_nxt = AD_RND;
          rnd_nxt   = rnd + RND_ONE;
        end
      end

      AD_RND: begin
        en_state_o = 1'b1;
        sel_ad_o   = 1'b1;
        if (rnd == RND_LAST) begin
          sel_xor_dom_sep_o = (ad_left == CNT_ZERO);
          if (ad_left != CNT_ZERO) begin
            state_nxt = AD_WAIT;
            rnd_nxt   = RND_PB_FIRST;
          end else begin
            state_nxt = PT_WAIT;
            rnd_nxt   = pt_wait_rnd;
          end
        end else begin
          rnd_nxt = rnd + RND_ONE;
        end
      end

      PT_WAIT: begin
        pt_ready_o = 1'b1;
        if (pt_valid_i) begin
          en_state_o    = 1'b1;
          sel_xor_ext_o = 1'b1;
          ct_valid_o    = 1'b1;
          if (pt_left != CNT_ZERO) begin
            pt_left_nxt = pt_left - CNT_ONE;
          end
          if (pt_last) begin
            sel_xor_fin_o = 1'b1;
            state_nxt     = FIN;
            rnd_nxt       = RND_ONE;
          end else begin
            state_nxt = PT_RND;
            rnd_nxt   = rnd + RND_ONE;
          end
        end
      end

      PT_RND: begin
        en_state_o = 1'b1;
        if (rnd == RND_LAST) begin
          state_nxt = PT_WAIT;
          rnd_nxt   = pt_wait_rnd;
        end else begin
          rnd_nxt = rnd + RND_ONE;
        end
      end

      FIN: begin
        en_state_o = 1'b1;
        if (rnd == RND_LAST) begin
          sel_xor_tag_o = 1'b1;
          state_nxt     = DONE;
          rnd_nxt       = RND_ZERO;
        end else begin
          rnd_nxt = rnd + RND_ONE;
        end
      end

      DONE: begin
        tag_valid_o = 1'b1;
        if (tag_ready_i) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        rnd_nxt   = RND_ZERO;
      end
    endcase

    if (abort) begin
      state_nxt   = IDLE;
      rnd_nxt     = RND_ZERO;
      ad_left_nxt = ad_left;
      pt_left_nxt = pt_left;
      en_state_o  = 1'b0;
      ad_ready_o  = 1'b0;
      pt_ready_o  = 1'b0;
      ct_valid_o  = 1'b0;
      tag_valid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// Self-checking bench for ascon_ctrl: a table of message shapes is expanded
// into a per-cycle plan of inputs and expected strobes; expectations are
// queued as each cycle is driven and compared when the outputs settle.
module tb_ascon_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] ad_blocks;
  logic [7:0] pt_blocks;
  logic       ad_valid;
  logic       ad_ready;
  logic       pt_valid;
  logic       pt_ready;
  logic       tag_ready;
  logic       abort;
  logic       busy;
  logic       en_state;
  logic       sel_ad;
  logic       sel_state_init;
  logic       sel_xor_init;
  logic       sel_xor_ext;
  logic       sel_xor_dom_sep;
  logic       sel_xor_fin;
  logic       sel_xor_tag;
  logic       ct_valid;
  logic       tag_valid;
  logic [3:0] rnd;

  int errors = 0;
  int checks = 0;
  int lat;

  localparam logic [12:0] F_BUSY  = 13'h1000;
  localparam logic [12:0] F_EN    = 13'h0800;
  localparam logic [12:0] F_SAD   = 13'h0400;
  localparam logic [12:0] F_SINIT = 13'h0200;
  localparam logic [12:0] F_XINIT = 13'h0100;
  localparam logic [12:0] F_XEXT  = 13'h0080;
  localparam logic [12:0] F_DOM   = 13'h0040;
  localparam logic [12:0] F_FIN   = 13'h0020;
  localparam logic [12:0] F_TAG   = 13'h0010;
  localparam logic [12:0] F_CT    = 13'h0008;
  localparam logic [12:0] F_TV    = 13'h0004;
  localparam logic [12:0] F_ADR   = 13'h0002;
  localparam logic [12:0] F_PTR   = 13'h0001;

  typedef struct {
    logic        rst;
    logic        start;
    logic        ad_valid;
    logic        pt_valid;
    logic        tag_ready;
    logic        abort;
    logic        mark;
    logic [12:0] flags;
    logic [3:0]  rnd;
    logic        chk_rnd;
  } step_t;

  typedef struct {
    int a;
    int p;
    int ad_stall;
    int pt_stall;
    int tag_hold;
    bit noise;
    int lat;
  } vec_t;

  step_t plan_q[$];
  step_t exp_q[$];
  vec_t  vecs[7];

  ascon_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start),
    .ad_blocks_i       (ad_blocks),
    .pt_blocks_i       (pt_blocks),
    .ad_valid_i        (ad_valid),
    .ad_ready_o        (ad_ready),
    .pt_valid_i        (pt_valid),
    .pt_ready_o        (pt_ready),
    .tag_ready_i       (tag_ready),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i           (abort),
`endif
    .busy_o            (busy),
    .en_state_o        (en_state),
    .sel_ad_o          (sel_ad),
    .sel_state_init_o  (sel_state_init),
    .sel_xor_init_o    (sel_xor_init),
    .sel_xor_ext_o     (sel_xor_ext),
    .sel_xor_dom_sep_o (sel_xor_dom_sep),
    .sel_xor_fin_o     (sel_xor_fin),
    .sel_xor_tag_o     (sel_xor_tag),
    .ct_valid_o        (ct_valid),
    .tag_valid_o       (tag_valid),
    .rnd_o             (rnd)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_step(input logic r, input logic st, input logic adv, input logic ptv,
                           input logic trdy, input logic ab, input logic mk,
                           input logic [12:0] f, input logic [3:0] rn, input logic chk);
    step_t s;
    s.rst = r; s.start = st; s.ad_valid = adv; s.pt_valid = ptv;
    s.tag_ready = trdy; s.abort = ab; s.mark = mk;
    s.flags = f; s.rnd = rn; s.chk_rnd = chk;
    plan_q.push_back(s);
  endtask

  // Expands one message into its expected cycle-by-cycle schedule.
  task automatic gen_message(input int a, input int p, input int ad_stall, input int pt_stall,
                             input int tag_hold, input bit noise);
    int          pe;
    logic [12:0] f;
    bit          last;
    logic [3:0]  wr;
    pe = (p == 0) ? 1 : p;
    ad_blocks = 8'(a);
    pt_blocks = 8'(p);
    push_step(0, 1, 1, 1, 0, 0, 1, 13'h0, 4'd0, 0);
    for (int r = 0; r < 12; r++) begin
      f = F_BUSY | F_EN;
      if (r == 0) f = f | F_SINIT;
      if (r == 11) begin
        f = f | F_XINIT;
        if (a == 0) f = f | F_DOM;
      end
      push_step(0, noise, 1, 1, 0, 0, 0, f, 4'(r), 1);
    end
    for (int b = 0; b < a; b++) begin
      for (int s = 0; s < ((b == 0) ? ad_stall : 0); s++)
        push_step(0, noise, 0, 1, 0, 0, 0, F_BUSY | F_SAD | F_ADR, 4'd6, 1);
      push_step(0, noise, 1, 1, 0, 0, 0, F_BUSY | F_EN | F_SAD | F_XEXT | F_ADR, 4'd6, 1);
      for (int r = 7; r < 12; r++) begin
        f = F_BUSY | F_EN | F_SAD;
        if (r == 11 && b == a - 1) f = f | F_DOM;
        push_step(0, noise, 1, 1, 0, 0, 0, f, 4'(r), 1);
      end
    end
    for (int b = 0; b < pe; b++) begin
      last = (b == pe - 1);
      wr   = last ? 4'd0 : 4'd6;
      for (int s = 0; s < ((b == 0) ? pt_stall : 0); s++)
        push_step(0, noise, 1, 0, 0, 0, 0, F_BUSY | F_PTR, wr, 1);
      f = F_BUSY | F_EN | F_XEXT | F_CT | F_PTR;
      if (last) f = f | F_FIN;
      push_step(0, noise, 1, 1, 0, 0, 0, f, wr, 1);
      if (!last) begin
        for (int r = 7; r < 12; r++)
          push_step(0, noise, 1, 1, 0, 0, 0, F_BUSY | F_EN, 4'(r), 1);
      end
    end
    for (int r = 1; r < 12; r++) begin
      f = F_BUSY | F_EN;
      if (r == 11) f = f | F_TAG;
      push_step(0, noise, 1, 1, 0, 0, 0, f, 4'(r), 1);
    end
    for (int h = 0; h < tag_hold; h++)
      push_step(0, noise, 1, 1, 0, 0, 0, F_BUSY | F_TV, 4'd0, 0);
    push_step(0, noise, 1, 1, 1, 0, 0, F_BUSY | F_TV, 4'd0, 0);
    push_step(0, 0, 1, 1, 0, 0, 0, 13'h0, 4'd0, 0);
  endtask

  task automatic applyStimulus(input step_t s);
    @(posedge clk);
    #1;
    rst       = s.rst;
    start     = s.start;
    ad_valid  = s.ad_valid;
    pt_valid  = s.pt_valid;
    tag_ready = s.tag_ready;
    abort     = s.abort;
    exp_q.push_back(s);
  endtask

  task automatic checkOutput(input string name, input int idx);
    step_t       e;
    logic [12:0] got;
    e   = exp_q.pop_front();
    got = {busy, en_state, sel_ad, sel_state_init, sel_xor_init, sel_xor_ext,
           sel_xor_dom_sep, sel_xor_fin, sel_xor_tag, ct_valid, tag_valid,
           ad_ready, pt_ready};
    checks++;
    if (got !== e.flags || (e.chk_rnd && rnd !== e.rnd)) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got flags=%b rnd=%0d, expected flags=%b rnd=%0d (rnd checked=%0b)",
               name, idx, got, rnd, e.flags, e.rnd, e.chk_rnd);
    end
  endtask

  task automatic run_plan(input string name);
    step_t s;
    int    cyc;
    int    idx;
    bit    marked;
    cyc    = 0;
    idx    = 0;
    marked = 0;
    lat    = -1;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      applyStimulus(s);
      @(negedge clk);
      if (s.mark) begin
        marked = 1;
        cyc    = 0;
      end else if (marked) begin
        cyc++;
      end
      if (marked && lat < 0 && tag_valid === 1'b1) lat = cyc;
      checkOutput(name, idx);
      idx++;
    end
  endtask

  task automatic check_latency(input string name, input int expected);
    checks++;
    if (lat != expected) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, lat, expected);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ad_valid = 1'b0; pt_valid = 1'b0;
    tag_ready = 1'b0; abort = 1'b0; ad_blocks = 8'd0; pt_blocks = 8'd0;

    vecs[0] = '{a: 0, p: 1, ad_stall: 0, pt_stall: 0, tag_hold: 0,  noise: 0, lat: 25};
    vecs[1] = '{a: 2, p: 3, ad_stall: 0, pt_stall: 0, tag_hold: 0,  noise: 0, lat: 49};
    vecs[2] = '{a: 1, p: 2, ad_stall: 5, pt_stall: 0, tag_hold: 0,  noise: 0, lat: 42};
    vecs[3] = '{a: 0, p: 1, ad_stall: 0, pt_stall: 0, tag_hold: 10, noise: 1, lat: 25};
    vecs[4] = '{a: 0, p: 0, ad_stall: 0, pt_stall: 0, tag_hold: 1,  noise: 0, lat: 25};
    vecs[5] = '{a: 3, p: 1, ad_stall: 0, pt_stall: 3, tag_hold: 0,  noise: 1, lat: 46};
    vecs[6] = '{a: 1, p: 4, ad_stall: 0, pt_stall: 2, tag_hold: 2,  noise: 0, lat: 51};

    push_step(1, 0, 0, 0, 0, 0, 0, 13'h0, 4'd0, 1);
    push_step(1, 1, 1, 1, 1, 0, 0, 13'h0, 4'd0, 1);
    push_step(0, 0, 0, 0, 0, 0, 0, 13'h0, 4'd0, 1);
    run_plan("reset");

    for (int i = 0; i < 7; i++) begin
      gen_message(vecs[i].a, vecs[i].p, vecs[i].ad_stall, vecs[i].pt_stall,
                  vecs[i].tag_hold, vecs[i].noise);
      run_plan($sformatf("vec%0d", i));
      check_latency($sformatf("vec%0d", i), vecs[i].lat);
    end

    ad_blocks = 8'd2;
    pt_blocks = 8'd1;
    push_step(0, 1, 1, 1, 0, 0, 0, 13'h0, 4'd0, 0);
    for (int r = 0; r < 6; r++)
      push_step((r == 5) ? 1'b1 : 1'b0, 0, 1, 1, 0, 0, 0,
                F_BUSY | F_EN | ((r == 0) ? F_SINIT : 13'h0), 4'(r), 1);
    push_step(0, 0, 1, 1, 0, 0, 0, 13'h0, 4'd0, 1);
    push_step(0, 0, 1, 1, 0, 0, 0, 13'h0, 4'd0, 1);
    run_plan("mid_reset");
    gen_message(0, 1, 0, 0, 0, 0);
    run_plan("after_reset");
    check_latency("after_reset", 25);

`ifdef ASCON_CTRL_ABORT_EN
    ad_blocks = 8'd0;
    pt_blocks = 8'd1;
    push_step(0, 1, 1, 1, 0, 0, 0, 13'h0, 4'd0, 0);
    for (int r = 0; r < 12; r++)
      push_step(0, 0, 1, 1, 0, 0, 0,
                F_BUSY | F_EN | ((r == 0) ? F_SINIT : 13'h0) |
                ((r == 11) ? (F_XINIT | F_DOM) : 13'h0), 4'(r), 1);
    push_step(0, 0, 1, 1, 0, 1, 0, F_BUSY | F_XEXT | F_FIN, 4'd0, 1);
    push_step(0, 0, 1, 1, 0, 0, 0, 13'h0, 4'd0, 0);
    push_step(0, 0, 1, 1, 0, 0, 0, 13'h0, 4'd0, 0);
    run_plan("abort");
    gen_message(1, 1, 0, 0, 0, 0);
    run_plan("after_abort");
    check_latency("after_abort", 31);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl.md
# ascon_ctrl

Sequencing controller for the Ascon-128 `permutation` datapath. It runs one authenticated encryption per `start_i`: 12-round initialization, 6-round absorption of each associated-data (AD) block, 6-round absorption of each non-final plaintext (PT) block, then 12-round finalization. It drives every select, enable and valid strobe of the datapath plus the round index. Message blocks arrive pre-padded, one 64-bit block per valid/ready handshake. The tag is held until the consumer acknowledges it.

## Interface
Parameters:
- `PA_ROUNDS`, 12: rounds for initialization and finalization; must equal `ROUND_NO`.
- `PB_ROUNDS`, 6: rounds per data block; the rounds used are `PA_ROUNDS-PB_ROUNDS` … `PA_ROUNDS-1`.
- `CNT_WIDTH`, 8: width of the block counts.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a message; sampled only in IDLE.
- `ad_blocks_i` in `CNT_WIDTH`: number of AD blocks (0 allowed); latched on start.
- `pt_blocks_i` in `CNT_WIDTH`: number of PT blocks (≥1); latched on start.
- `ad_valid_i` / `ad_ready_o`: AD block handshake.
- `pt_valid_i` / `pt_ready_o`: PT block handshake.
- `tag_ready_i` in 1: tag consumed.
- `busy_o` out 1: high in every state except IDLE.
- `en_state_o`, `sel_ad_o`, `sel_state_init_o`, `sel_xor_init_o`, `sel_xor_ext_o`, `sel_xor_dom_sep_o`, `sel_xor_fin_o`, `sel_xor_tag_o`, `ct_valid_o`, `tag_valid_o`: out 1 each; connect to the same-named datapath inputs.
- `rnd_o` out `ROUND_WIDTH`: round index to the datapath.

## Operation
States: IDLE, INIT, AD_WAIT, AD_RND, PT_WAIT, PT_RND, FIN, DONE.

- **IDLE**
  - On `start_i`: latch counts into `ad_left` / `pt_left`, go to INIT with `rnd_o`=0.
- **INIT**
  - One round per cycle, `rnd_o` 0→11, `en_state_o`=1.
  - `sel_state_init_o`=1 at `rnd_o`=0.
  - At `rnd_o`=11: `sel_xor_init_o`=1, and `sel_xor_dom_sep_o`=1 if `ad_left`==0.
  - Exit to AD_WAIT if `ad_left`≠0, else PT_WAIT.
- **AD_WAIT**
  - `ad_ready_o`=1, `sel_ad_o`=1, `rnd_o`=6.
  - On `ad_valid_i`: this cycle is round 6, with `en_state_o`=`sel_xor_ext_o`=1 combinationally from `ad_valid_i`. Decrement `ad_left`, go to AD_RND.
- **AD_RND**
  - Rounds 7→11, `sel_ad_o`=1.
  - At round 11 of the last block (`ad_left`==0): `sel_xor_dom_sep_o`=1.
  - Exit to AD_WAIT if `ad_left`≠0, else PT_WAIT.
- **PT_WAIT**
  - `pt_ready_o`=1.
  - `rnd_o`=6 if `pt_left`>1, else 0.
  - On `pt_valid_i`: `en_state_o`=`sel_xor_ext_o`=`ct_valid_o`=1. Decrement `pt_left`.
  - If this is the final block: also `sel_xor_fin_o`=1, go to FIN at `rnd_o`=1. Otherwise go to PT_RND.
- **PT_RND**
  - Rounds 7→11, then PT_WAIT.
- **FIN**
  - Rounds 1→11.
  - At 11: `sel_xor_tag_o`=1, then DONE.
- **DONE**
  - `tag_valid_o`=1, `en_state_o`=0.
  - On `tag_ready_i`: go to IDLE.

Rules:
- `start_i` outside IDLE is ignored.
- `en_state_o`=0 in IDLE, DONE, and WAIT states without valid.
- Select strobes not listed for a state are 0.
- `ready` is state-decoded. Only the strobes that depend on `valid` are combinational.
- `pt_blocks_i`=0 is treated as 1.
- Counters decrement exactly once per handshake and never wrap.

## Timing
- Reset: state IDLE; all outputs 0, including `rnd_o`; counters 0. Reset mid-message abandons it with no further strobes. Datapath state contents are don't-care.
- `rnd_o` and state are registered.
- Handshake-to-strobe delay is zero cycles: the data is consumed in the cycle `valid`&`ready` is high.
- With `valid` held high, start (cycle 0) to first `tag_valid_o` cycle = 25 + 6·A + 6·(P−1).
- Stalls in a WAIT state add cycles one-for-one. The datapath state is frozen during a stall.

## Configuration
- `ASCON_CTRL_ABORT_EN` defined:
  - Adds input `abort_i`.
  - `abort_i`=1 in any state forces IDLE next cycle.
  - In the abort cycle, `en_state_o`, `ready`, `ct_valid_o` and `tag_valid_o` are forced to 0.
  - Abort has priority over every handshake.
- Undefined: no `abort_i` port; only `rst` abandons a message.

## Test plan
- A=0, P=1, valids high: `sel_state_init_o` at cycle 1; `sel_xor_init_o`+`sel_xor_dom_sep_o` at cycle 12; `sel_xor_ext_o`+`sel_xor_fin_o`+`ct_valid_o` at 13 with `rnd_o`=0; `sel_xor_tag_o` at 24; `tag_valid_o` from 25.
- A=2, P=3: AD transfers at 13 and 19 with `rnd_o`=6; dom-sep only at cycle 24; PT transfers at 25, 31, 37; `tag_valid_o` at 49. The resulting tag matches the Ascon-128 reference vector for the same key, nonce and data.
- A=1, P=2, `ad_valid_i` withheld 5 cycles in AD_WAIT: `en_state_o`=0 throughout the stall; schedule shifts by 5; same tag as the unstalled run.
- `start_i` pulsed during FIN, and `tag_ready_i` held low 10 cycles in DONE: no restart; `tag_valid_o` held for all 10 cycles; IDLE one cycle after `tag_ready_i`.
- `rst` asserted at INIT round 5: next cycle IDLE, all outputs 0; a new start then completes normally.
- With `ASCON_CTRL_ABORT_EN`: `abort_i` during a PT_WAIT transfer → no `ct_valid_o`, IDLE next cycle, `busy_o`=0.
